// File: rtl/core_mem_arb.sv
// Three-requester single-port memory arbiter (fetch, lsu, front panel) with optional round-robin and bus lock.
// Latency: zero-cycle grant in ARB; read response one cycle after the accepted read.
// Backpressure: mem_rdy_i low registers the winner (HOLD) and keeps it on the memory port until accepted.
module core_mem_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  req_val_i,
  input  logic [2:0]  req_wen_i,
  input  logic [23:0] req_addr_i,
  input  logic [47:0] req_wdata_i,
  output logic [2:0]  req_rdy_o,
  output logic [2:0]  rsp_val_o,
  output logic [15:0] rsp_data_o,
  input  logic        lock_i,
  output logic        mem_val_o,
  output logic        mem_wen_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_rdy_i,
  input  logic [15:0] mem_rdata_i
);

  typedef enum logic {ARB, HOLD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  rsp_q, rsp_d;

  logic [2:0]  elig;
  logic [1:0]  start;
  logic [2:0]  cand;
  logic [1:0]  win;
  logic        win_vld;
  logic [1:0]  gnt;
  logic        gnt_vld;
  logic [2:0]  gnt_oh;
  logic        acc;

  // Winner search over eligible requesters; lock narrows eligibility to the front panel.
  always_comb begin
    elig    = lock_i ? (req_val_i & 3'b100) : req_val_i;
    start   = (RR_EN && last_q != 2'd2) ? (last_q + 2'd1) : 2'd0;
    cand    = 3'd0;
    win     = 2'd0;
    win_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, start} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_vld && elig[cand[1:0]]) begin
        win     = cand[1:0];
        win_vld = 1'b1;
      end
    end
  end

  // Grant source: registered owner in HOLD, live winner in ARB; nothing while reset is held.
  always_comb begin
    gnt     = 2'd0;
    gnt_vld = 1'b0;
    if (!rst_i) begin
      if (state_q == HOLD) begin
        gnt     = owner_q;
        gnt_vld = 1'b1;
      end else begin
        gnt     = win;
        gnt_vld = win_vld;
      end
    end
    gnt_oh = 3'b000;
    if (gnt_vld) begin
      case (gnt)
        2'd0:    gnt_oh = 3'b001;
        2'd1:    gnt_oh = 3'b010;
        default: gnt_oh = 3'b100;
      endcase
    end
    acc = gnt_vld & mem_rdy_i;
  end

  // Memory port mux and per-requester accept.
  always_comb begin
    mem_val_o   = gnt_vld;
    mem_wen_o   = 1'b0;
    mem_addr_o  = 8'h00;
    mem_wdata_o = 16'h0000;
    case (gnt_oh)
      3'b001: begin
        mem_wen_o   = req_wen_i[0];
        mem_addr_o  = req_addr_i[7:0];
        mem_wdata_o = req_wdata_i[15:0];
      end
      3'b010: begin
        mem_wen_o   = req_wen_i[1];
        mem_addr_o  = req_addr_i[15:8];
        mem_wdata_o = req_wdata_i[31:16];
      end
      3'b100: begin
        mem_wen_o   = req_wen_i[2];
        mem_addr_o  = req_addr_i[23:16];
        mem_wdata_o = req_wdata_i[47:32];
      end
      default: ;
    endcase
    req_rdy_o = acc ? gnt_oh : 3'b000;
  end

  // Next-state: enter HOLD on a stalled ARB grant, leave on accept; track last grant and read owner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rsp_d   = 3'b000;
    if (state_q == ARB && gnt_vld && !mem_rdy_i) begin
      state_d = HOLD;
      owner_d = gnt;
    end else if (state_q == HOLD && mem_rdy_i) begin
      state_d = ARB;
    end
    if (acc) begin
      last_d = gnt;
      if (!mem_wen_o) rsp_d = gnt_oh;
    end
  end

  // State registers; reset discards any held grant or pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      rsp_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
    end
  end

  // Response outputs; masked while reset is held so a pending read never pulses.
  always_comb begin
    rsp_val_o  = rst_i ? 3'b000 : rsp_q;
    rsp_data_o = (|rsp_val_o) ? mem_rdata_i : 16'h0000;
  end

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed bench for core_mem_arb: per-cycle vector table plus fixed-priority sequences.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Two instances share inputs: round-robin (main table) and fixed priority.
module tb_core_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_val, req_wen;
  logic [23:0] req_addr;
  logic [47:0] req_wdata;
  logic        lock, mem_rdy;
  logic [15:0] mem_rdata;

  logic [2:0]  rr_rdy, rr_rsp;
  logic [15:0] rr_rdat, rr_wdata;
  logic        rr_mval, rr_mwen;
  logic [7:0]  rr_maddr;

  logic [2:0]  fp_rdy, fp_rsp;
  logic [15:0] fp_rdat, fp_wdata;
  logic        fp_mval, fp_mwen;
  logic [7:0]  fp_maddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_mem_arb #(.RR_EN(1'b1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_val_i(req_val), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rdy_o(rr_rdy),
    .rsp_val_o(rr_rsp), .rsp_data_o(rr_rdat), .lock_i(lock),
    .mem_val_o(rr_mval), .mem_wen_o(rr_mwen), .mem_addr_o(rr_maddr),
    .mem_wdata_o(rr_wdata), .mem_rdy_i(mem_rdy), .mem_rdata_i(mem_rdata)
  );

  core_mem_arb #(.RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .req_val_i(req_val), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rdy_o(fp_rdy),
    .rsp_val_o(fp_rsp), .rsp_data_o(fp_rdat), .lock_i(lock),
    .mem_val_o(fp_mval), .mem_wen_o(fp_mwen), .mem_addr_o(fp_maddr),
    .mem_wdata_o(fp_wdata), .mem_rdy_i(mem_rdy), .mem_rdata_i(mem_rdata)
  );

  // Fixed per-requester address and write data.
  localparam logic [7:0]  A0 = 8'hA0, A1 = 8'h10, A2 = 8'hC2;
  localparam logic [15:0] D0 = 16'h1111, D1 = 16'hBEEF, D2 = 16'h3333;

  typedef struct {
    logic        rst;
    logic [2:0]  val;
    logic [2:0]  wen;
    logic        lock;
    logic        mrdy;
    logic [15:0] rdata;
    int          gnt;   // expected granted requester, 3 = none
    logic [2:0]  rsp;   // expected rsp_val_o
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] v, input logic [2:0] w, input logic lk,
                     input logic mr, input logic [15:0] rd, input int g, input logic [2:0] rs);
    vec_t t;
    t.rst = r; t.val = v; t.wen = w; t.lock = lk; t.mrdy = mr; t.rdata = rd; t.gnt = g; t.rsp = rs;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] v, input logic [2:0] w, input logic lk,
                       input logic mr, input logic [15:0] rd);
    rst = r; req_val = v; req_wen = w; lock = lk; mem_rdy = mr; mem_rdata = rd;
  endtask

  initial begin
    logic [7:0]  addr_tab [3];
    logic [15:0] wd_tab [3];
    logic [2:0]  e_rdy;
    logic [15:0] e_rdat;

    addr_tab[0] = A0; addr_tab[1] = A1; addr_tab[2] = A2;
    wd_tab[0] = D0; wd_tab[1] = D1; wd_tab[2] = D2;
    req_addr  = {A2, A1, A0};
    req_wdata = {D2, D1, D0};
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 16'h0);

    //   rst  val     wen     lock  mrdy  rdata      gnt rsp
    add(1'b1, 3'b111, 3'b000, 1'b0, 1'b1, 16'h0000, 3, 3'b000); // outputs idle while in reset
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0000, 3, 3'b000);
    // round-robin reads from reset: 0,1,2,0 with responses a cycle later
    add(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 16'h0000, 0, 3'b000);
    add(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 16'hAAA0, 1, 3'b001);
    add(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 16'hAAA1, 2, 3'b010);
    add(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 16'hAAA2, 0, 3'b100);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'hAAA3, 3, 3'b001);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'h5555, 3, 3'b000);
    // requester 1 write stalled two cycles; requester 0 arrives mid-hold
    add(1'b0, 3'b010, 3'b010, 1'b0, 1'b0, 16'h0000, 1, 3'b000);
    add(1'b0, 3'b011, 3'b010, 1'b0, 1'b0, 16'h0000, 1, 3'b000);
    add(1'b0, 3'b011, 3'b010, 1'b0, 1'b1, 16'h0000, 1, 3'b000);
    add(1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 16'h7777, 0, 3'b000);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'h1234, 3, 3'b001);
    // lock: only requester 2 eligible
    add(1'b0, 3'b011, 3'b000, 1'b1, 1'b1, 16'h0000, 3, 3'b000);
    add(1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 16'h0000, 2, 3'b000);
    add(1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 16'h0B0B, 2, 3'b100);
    add(1'b0, 3'b011, 3'b000, 1'b0, 1'b1, 16'h0C0C, 0, 3'b100);
    add(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 16'h0D0D, 1, 3'b001);
    // lock raised while requester 0 is held: it still completes first
    add(1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 16'h0E0E, 0, 3'b010);
    add(1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 16'h0000, 0, 3'b000);
    add(1'b0, 3'b101, 3'b000, 1'b1, 1'b1, 16'h0000, 0, 3'b000);
    add(1'b0, 3'b100, 3'b000, 1'b1, 1'b1, 16'h0F0F, 2, 3'b001);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'h1010, 3, 3'b100);
    // requester 2 read, then reset: response dropped, pointer back to 0
    add(1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 16'h0000, 2, 3'b000);
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 16'h2222, 3, 3'b000);
    add(1'b0, 3'b110, 3'b000, 1'b0, 1'b1, 16'h2323, 1, 3'b000);
    add(1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 16'h3434, 2, 3'b010);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'h4444, 3, 3'b100);
    // reset in HOLD abandons the held grant
    add(1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 16'h0000, 0, 3'b000);
    add(1'b1, 3'b001, 3'b000, 1'b0, 1'b1, 16'h0000, 3, 3'b000);
    add(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'h5656, 3, 3'b000);
    add(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 16'h0000, 1, 3'b000);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].val, vecs[i].wen, vecs[i].lock, vecs[i].mrdy, vecs[i].rdata);
      @(negedge clk);
      e_rdy  = (vecs[i].gnt != 3 && vecs[i].mrdy) ? (3'b001 << vecs[i].gnt) : 3'b000;
      e_rdat = (vecs[i].rsp != 3'b000) ? vecs[i].rdata : 16'h0000;
      check($sformatf("v%0d req_rdy", i), {29'd0, rr_rdy}, {29'd0, e_rdy});
      check($sformatf("v%0d mem_val", i), {31'd0, rr_mval}, {31'd0, vecs[i].gnt != 3});
      check($sformatf("v%0d mem_addr", i), {24'd0, rr_maddr},
            {24'd0, (vecs[i].gnt != 3) ? addr_tab[vecs[i].gnt] : 8'h00});
      check($sformatf("v%0d mem_wdata", i), {16'd0, rr_wdata},
            {16'd0, (vecs[i].gnt != 3) ? wd_tab[vecs[i].gnt] : 16'h0000});
      check($sformatf("v%0d mem_wen", i), {31'd0, rr_mwen},
            {31'd0, (vecs[i].gnt != 3) ? vecs[i].wen[vecs[i].gnt] : 1'b0});
      check($sformatf("v%0d rsp_val", i), {29'd0, rr_rsp}, {29'd0, vecs[i].rsp});
      check($sformatf("v%0d rsp_data", i), {16'd0, rr_rdat}, {16'd0, e_rdat});
    end

    // Fixed priority vs round-robin with all three requesting, from reset.
    @(posedge clk); #1; drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 16'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; drive(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 16'h0);
      @(negedge clk);
      check($sformatf("fp_all c%0d", c), {29'd0, fp_rdy}, 32'd1);
      check($sformatf("rr_all c%0d", c), {29'd0, rr_rdy}, 32'd1 << c);
    end
    // Fixed priority picks lowest index among 1 and 2; lock drop-through to 2.
    @(posedge clk); #1; drive(1'b0, 3'b110, 3'b000, 1'b0, 1'b1, 16'h0);
    @(negedge clk);
    check("fp_110", {29'd0, fp_rdy}, 32'b010);
    @(posedge clk); #1; drive(1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 16'h0);
    @(negedge clk);
    check("fp_lock", {29'd0, fp_rdy}, 32'b100);
    check("fp_lock_addr", {24'd0, fp_maddr}, {24'd0, A2});
    @(posedge clk); #1; drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 16'h9999);
    @(negedge clk);
    check("fp_rsp", {29'd0, fp_rsp}, 32'b100);
    check("fp_rsp_data", {16'd0, fp_rdat}, 32'h9999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_arb.md
CORE_MEM_ARB -- requirements
Module: core_mem_arb

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 highest, then 1, then 2.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req_val_i  input  3  per-requester request valid: bit0 fetch, bit1 lsu, bit2 front panel.
REQ-005 req_wen_i  input  3  per-requester write enable (1 = write, 0 = read).
REQ-006 req_addr_i  input  24  per-requester 8-bit address; requester n occupies bits [8n+7:8n].
REQ-007 req_wdata_i  input  48  per-requester 16-bit write data; requester n occupies bits [16n+15:16n].
REQ-008 req_rdy_o  output  3  per-requester accept; a transaction completes on a cycle where req_val_i[n] and req_rdy_o[n] are both 1.
REQ-009 rsp_val_o  output  3  per-requester read-response valid, one-cycle pulse.
REQ-010 rsp_data_o  output  16  read data, shared by all requesters and qualified by rsp_val_o.
REQ-011 lock_i  input  1  front-panel bus lock; while 1, grant stays with requester 2.
REQ-012 mem_val_o, mem_wen_o  output  1 each  memory port request and write enable.
REQ-013 mem_addr_o  output  8  memory address.
REQ-014 mem_wdata_o  output  16  memory write data.
REQ-015 mem_rdy_i  input  1  memory accept.
REQ-016 mem_rdata_i  input  16  memory read data, valid in the cycle after an accepted read.

Function
REQ-017 Requester rule: once req_val_i[n] is raised, it and that requester's wen/addr/wdata stay stable until accepted.
REQ-018 States: ARB (no grant outstanding) and HOLD (grant registered, memory not yet accepted).
REQ-019 Winner selection in ARB is combinational from req_val_i (zero-cycle grant).
  - RR_EN=1: search starts at (last_grant+1) mod 3.
  - RR_EN=0: lowest index wins.
REQ-020 In ARB with any req_val_i set:
  - mem_val_o=1; mem_wen/addr/wdata are muxed from the winner.
  - req_rdy_o[winner]=mem_rdy_i; all other req_rdy_o bits are 0.
REQ-021 In ARB, if mem_rdy_i=0 the winner is registered and the block enters HOLD.
REQ-022 In HOLD, the registered requester drives the memory port regardless of other req_val_i; the block returns to ARB on the cycle mem_rdy_i=1.
REQ-023 last_grant updates to the winner on every accepted transaction.
REQ-024 Lock override: while lock_i=1 and the block is in ARB, requester 2 is the only eligible requester.
  - If req_val_i[2]=0, mem_val_o=0 and all req_rdy_o bits are 0.
  - lock_i asserting while in HOLD for another requester takes effect only after that transaction is accepted.
REQ-025 Read response: on an accepted read by requester n, the next cycle has rsp_val_o[n]=1 and rsp_data_o=mem_rdata_i; the owner index is registered for this.
REQ-026 rsp_data_o is 0 when rsp_val_o is all-zero.
REQ-027 Back-to-back accepted transactions (one per cycle) are supported; a response pulse may coincide with a new acceptance.
REQ-028 Accepted writes produce no response.
REQ-029 With no eligible request: mem_val_o=0, mem_wen/addr/wdata are 0, and req_rdy_o is 0.
REQ-030 At most one bit of req_rdy_o and at most one bit of rsp_val_o are 1 in any cycle.

Reset
REQ-031 While rst_i=1:
  - state goes to ARB and last_grant to 2, so requester 0 is searched first after reset.
  - the registered owner clears, and rsp_val_o is 0 in the cycle after reset asserts.
REQ-032 Reset mid-HOLD or with a read response pending discards that transaction; no rsp_val_o pulse follows.
REQ-033 Outputs during and directly after reset follow REQ-029 until a request is presented.

Verification
REQ-034 RR_EN=1, all three requesting reads with mem_rdy_i=1 from reset -> grants in order 0,1,2,0; each rsp_val_o bit pulses one cycle after its grant, carrying the stubbed mem_rdata_i.
REQ-035 RR_EN=0, req_val_i=3'b111 held for 3 cycles -> req_rdy_o=3'b001 every cycle.
REQ-036 Requester 1 writes addr 8'h10, data 16'hBEEF, with mem_rdy_i=0 for 2 cycles; requester 0 raises val in the second cycle -> mem_addr_o stays 8'h10; requester 1 is accepted in cycle 3; requester 0 is granted in cycle 4; no rsp_val_o pulse for the write.
REQ-037 lock_i=1, req_val_i=3'b011 -> mem_val_o=0, req_rdy_o=0; then req_val_i[2]=1 -> requester 2 granted repeatedly until lock_i drops.
REQ-038 Requester 2 read accepted, then rst_i=1 in the next cycle -> rsp_val_o stays 0; after reset with req_val_i=3'b110, requester 1 wins first.
